// File: rtl/switch_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : switch_out_arbiter
// Purpose  : Round-robin packet arbiter and mux for one switch egress port,
//            grant held for a whole packet, watchdog on a stalled source.
// Revision : 1.0
// ============================================================================
module switch_out_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 8,
   parameter int TIMEOUT   = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_PORTS-1:0]          in_valid,
   input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
   input  logic [NUM_PORTS-1:0]          in_eop,
   output logic [NUM_PORTS-1:0]          in_ready,
   output logic                          out_valid,
   output logic [DATA_W-1:0]             out_data,
   output logic                          out_eop,
   input  logic                          out_ready,
   output logic                          busy,
   output logic [$clog2(NUM_PORTS)-1:0]  grant_id,
   output logic                          timeout_err
);

   localparam int PW = $clog2(NUM_PORTS);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [PW-1:0] PTR_LAST = PW'(NUM_PORTS - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [PW-1:0]       r_grant, w_grant_nxt;
   logic [PW-1:0]       r_rr_ptr, w_rr_ptr_nxt;
   logic [CW-1:0]       r_idle_cnt, w_idle_cnt_nxt;
   logic                r_timeout_err, w_timeout_err_nxt;

   logic                w_found;
   logic [PW-1:0]       w_sel;
   int                  w_best_dist;
   int                  w_dist;
   logic [NUM_PORTS-1:0] w_grant_mask;
   logic                w_src_valid;
   logic                w_src_eop;
   logic [DATA_W-1:0]   w_src_data;
   logic [PW-1:0]       w_ptr_after;

   // Pick the requester with the smallest distance from rr_ptr, modulo NUM_PORTS.
   always_comb begin
      w_found     = 1'b0;
      w_sel       = '0;
      w_best_dist = NUM_PORTS;
      w_dist      = 0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         w_dist = (p + NUM_PORTS - int'(r_rr_ptr)) % NUM_PORTS;
         if (in_valid[p] && (w_dist < w_best_dist)) begin
            w_found     = 1'b1;
            w_sel       = PW'(p);
            w_best_dist = w_dist;
         end
      end
   end

   always_comb begin
      w_grant_mask = '0;
      w_src_valid  = 1'b0;
      w_src_eop    = 1'b0;
      w_src_data   = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (r_grant == PW'(p)) begin
            w_grant_mask[p] = 1'b1;
            w_src_valid     = in_valid[p];
            w_src_eop       = in_eop[p];
            w_src_data      = in_data[p*DATA_W +: DATA_W];
         end
      end
   end

   assign w_ptr_after = (r_grant == PTR_LAST) ? '0 : r_grant + 1'b1;

   always_comb begin
      w_state_nxt       = r_state;
      w_grant_nxt       = r_grant;
      w_rr_ptr_nxt      = r_rr_ptr;
      w_idle_cnt_nxt    = r_idle_cnt;
      w_timeout_err_nxt = 1'b0;
      out_valid         = 1'b0;
      out_data          = '0;
      out_eop           = 1'b0;
      in_ready          = '0;
      case (r_state)
         ST_IDLE: begin
            w_idle_cnt_nxt = '0;
            if (w_found) begin
               w_grant_nxt = w_sel;
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            out_valid = w_src_valid;
            out_data  = w_src_data;
            out_eop   = w_src_eop;
            in_ready  = w_grant_mask & {NUM_PORTS{out_ready}};
            if (w_src_valid) begin
               // A live source resets the watchdog even while downstream stalls.
               w_idle_cnt_nxt = '0;
               if (out_ready && w_src_eop) begin
                  w_state_nxt  = ST_IDLE;
                  w_rr_ptr_nxt = w_ptr_after;
               end
            end else if (TIMEOUT > 0) begin
               if (r_idle_cnt == CNT_LAST) begin
                  w_state_nxt       = ST_IDLE;
                  w_rr_ptr_nxt      = w_ptr_after;
                  w_idle_cnt_nxt    = '0;
                  w_timeout_err_nxt = 1'b1;
               end else if (r_idle_cnt != CNT_MAX) begin
                  w_idle_cnt_nxt = r_idle_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_grant       <= '0;
         r_rr_ptr      <= '0;
         r_idle_cnt    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_grant       <= w_grant_nxt;
         r_rr_ptr      <= w_rr_ptr_nxt;
         r_idle_cnt    <= w_idle_cnt_nxt;
         r_timeout_err <= w_timeout_err_nxt;
      end
   end

   assign busy        = (r_state == ST_BUSY);
   assign grant_id    = (r_state == ST_BUSY) ? r_grant : '0;
   assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_switch_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_out_arbiter
// Purpose  : Directed stimulus for switch_out_arbiter, checked every cycle
//            against a packet-level model plus hand-computed expectations.
// Revision : 1.0
// ============================================================================
module tb_switch_out_arbiter;

   localparam int NP = 4;
   localparam int DW = 8;
   localparam int TO = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [NP-1:0]  in_valid;
   logic [NP*DW-1:0] in_data;
   logic [NP-1:0]  in_eop;
   logic [NP-1:0]  in_ready;
   logic           out_valid;
   logic [DW-1:0]  out_data;
   logic           out_eop;
   logic           out_ready;
   logic           busy;
   logic [1:0]     grant_id;
   logic           timeout_err;

   int checks = 0;
   int errors = 0;

   switch_out_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_eop(in_eop), .in_ready(in_ready), .out_valid(out_valid),
      .out_data(out_data), .out_eop(out_eop), .out_ready(out_ready),
      .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Packet-level model: who owns the output, where the next search starts,
   // and how many consecutive cycles the owner has been silent.
   bit m_on = 1'b0;
   int m_busy = 0, m_grant = 0, m_ptr = 0, m_silent = 0, m_terr = 0;

   always @(posedge clk) begin : model
      int nb, ng, np, ns, nt, idx;
      bit gv, ge;
      nb = m_busy; ng = m_grant; np = m_ptr; ns = m_silent; nt = 0;
      if (rst) begin
         nb = 0; ng = 0; np = 0; ns = 0;
      end else if (!m_busy) begin
         for (int k = NP - 1; k >= 0; k--) begin
            idx = (m_ptr + k) % NP;
            if (((in_valid >> idx) & 1) != 0) begin
               ng = idx;
               nb = 1;
            end
         end
         ns = 0;
      end else begin
         gv = ((in_valid >> m_grant) & 1) != 0;
         ge = ((in_eop >> m_grant) & 1) != 0;
         if (gv) begin
            ns = 0;
            if (out_ready && ge) begin
               nb = 0;
               np = (m_grant + 1) % NP;
            end
         end else begin
            ns = m_silent + 1;
            if (ns == TO) begin
               nb = 0; nt = 1; ns = 0;
               np = (m_grant + 1) % NP;
            end
         end
      end
      if (rst) m_on <= 1'b1;
      m_busy <= nb; m_grant <= ng; m_ptr <= np; m_silent <= ns; m_terr <= nt;
   end

   always @(negedge clk) begin : compare
      logic ev, ee;
      logic [DW-1:0] ed;
      logic [NP-1:0] er;
      if (m_on) begin
         ev = 1'b0; ee = 1'b0; ed = '0; er = '0;
         if (m_busy != 0) begin
            ev = 1'((in_valid >> m_grant) & 1);
            ee = 1'((in_eop >> m_grant) & 1);
            ed = DW'(in_data >> (m_grant * DW));
            er = out_ready ? NP'(1 << m_grant) : '0;
         end
         chk("m_busy", busy, 32'(m_busy));
         chk("m_grant_id", grant_id, (m_busy != 0) ? 32'(m_grant) : 0);
         chk("m_out_valid", out_valid, ev);
         chk("m_out_data", out_data, ed);
         chk("m_out_eop", out_eop, ee);
         chk("m_in_ready", in_ready, er);
         chk("m_timeout_err", timeout_err, 32'(m_terr));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input bit v, input bit e, input logic [DW-1:0] d);
      logic [NP-1:0] m;
      m = NP'(1 << p);
      in_valid = v ? (in_valid | m) : (in_valid & ~m);
      in_eop   = e ? (in_eop | m) : (in_eop & ~m);
      in_data  = (in_data & ~(32'hFF << (p * DW))) | (32'(d) << (p * DW));
   endtask

   task automatic clear_ports();
      in_valid = '0;
      in_eop   = '0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin : stim
      rst = 1'b1; in_valid = '0; in_eop = '0; in_data = '0; out_ready = 1'b0;
      cyc(); cyc();
      #1;
      chk("rst_state", {busy, grant_id, out_valid, in_ready, timeout_err},
          {1'b0, 2'd0, 1'b0, 4'd0, 1'b0});

      // Every port offers 1-beat packets: grants rotate with one bubble each.
      rst = 1'b0; out_ready = 1'b1;
      for (int p = 0; p < NP; p++) set_port(p, 1'b1, 1'b1, DW'(8'h10 + p));
      for (int k = 0; k < 8; k++) begin
         cyc(); #1;
         chk("rr_grant", grant_id, 32'(k % NP));
         chk("rr_data", out_data, 32'(8'h10 + (k % NP)));
         cyc(); #1;
         chk("rr_bubble", {busy, out_valid}, 2'b00);
      end
      clear_ports();

      // 3-beat packet from port 2 with downstream stalls; port 0 waits.
      set_port(2, 1'b1, 1'b0, 8'hA1);
      cyc(); #1;
      chk("pkt_a1", {grant_id, out_data}, {2'd2, 8'hA1});
      cyc();
      set_port(2, 1'b1, 1'b0, 8'hA2); set_port(0, 1'b1, 1'b1, 8'h55); out_ready = 1'b0;
      #1;
      chk("pkt_a2_stall", {grant_id, out_data, in_ready}, {2'd2, 8'hA2, 4'b0000});
      cyc(); out_ready = 1'b1; #1;
      chk("pkt_a2_go", {grant_id, out_data, in_ready}, {2'd2, 8'hA2, 4'b0100});
      cyc();
      set_port(2, 1'b1, 1'b1, 8'hA3); out_ready = 1'b0;
      #1;
      chk("pkt_a3_stall", {grant_id, out_data, out_eop}, {2'd2, 8'hA3, 1'b1});
      cyc(); out_ready = 1'b1; #1;
      chk("pkt_a3_go", {grant_id, out_data, out_eop}, {2'd2, 8'hA3, 1'b1});
      cyc();
      set_port(2, 1'b0, 1'b0, 8'h00);
      #1;
      chk("pkt_release", {busy, grant_id}, {1'b0, 2'd0});
      cyc(); #1;
      chk("pkt_next_p0", {grant_id, out_data}, {2'd0, 8'h55});
      cyc(); clear_ports();

      // Port 2 finishes, so ports 0 and 3 together resolve to 3 first.
      set_port(2, 1'b1, 1'b1, 8'h22);
      cyc(); #1;
      chk("ptr_g2", grant_id, 2'd2);
      cyc(); clear_ports();
      set_port(0, 1'b1, 1'b1, 8'h66); set_port(3, 1'b1, 1'b1, 8'h77);
      #1;
      chk("ptr_idle", busy, 1'b0);
      cyc(); #1;
      chk("ptr_g3_first", {grant_id, out_data}, {2'd2 + 2'd1, 8'h77});
      cyc();
      set_port(3, 1'b0, 1'b0, 8'h00);
      cyc(); #1;
      chk("ptr_g0_next", {grant_id, out_data}, {2'd0, 8'h66});
      cyc(); clear_ports();

      // Watchdog: one non-eop beat from port 1, then silence.
      set_port(1, 1'b1, 1'b0, 8'h31);
      cyc(); #1;
      chk("wd_grant", {busy, grant_id, out_data}, {1'b1, 2'd1, 8'h31});
      cyc(); clear_ports();
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("wd_wait", {busy, timeout_err}, 2'b10);
         cyc();
      end
      #1;
      chk("wd_fire", {busy, timeout_err}, 2'b01);
      cyc(); #1;
      chk("wd_pulse_end", timeout_err, 1'b0);
      set_port(1, 1'b1, 1'b1, 8'h41); set_port(2, 1'b1, 1'b1, 8'h42);
      cyc(); #1;
      chk("wd_ptr2", {grant_id, out_data}, {2'd2, 8'h42});
      cyc(); clear_ports();

      // A stalled downstream with a live source never times out.
      set_port(1, 1'b1, 1'b0, 8'h51); out_ready = 1'b0;
      cyc();
      for (int k = 0; k < 100; k++) begin
         cyc(); #1;
         chk("stall_hold", {timeout_err, busy, grant_id}, {1'b0, 1'b1, 2'd1});
      end
      set_port(1, 1'b1, 1'b1, 8'h52); out_ready = 1'b1;
      cyc(); clear_ports();

      // Reset in the middle of a 4-beat packet from port 3.
      set_port(3, 1'b1, 1'b0, 8'h91);
      cyc(); #1;
      chk("mid_grant", {grant_id, out_data}, {2'd3, 8'h91});
      cyc();
      set_port(3, 1'b1, 1'b0, 8'h92); rst = 1'b1;
      #1;
      chk("mid_beat2", out_data, 8'h92);
      cyc();
      rst = 1'b0;
      set_port(0, 1'b1, 1'b1, 8'h66); set_port(3, 1'b1, 1'b1, 8'h93);
      #1;
      chk("mid_reset", {busy, out_valid, in_ready, grant_id}, {1'b0, 1'b0, 4'd0, 2'd0});
      cyc(); #1;
      chk("mid_rearb_p0", {grant_id, out_data}, {2'd0, 8'h66});
      cyc(); clear_ports();
      cyc(); cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
